// File: rtl/rr_arb_mux_4.sv
// Four-channel round-robin arbiter with a one-entry output register.
// The register drives the data and select stream of the downstream 4:1 nibble mux.
module rr_arb_mux_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_sel;
  logic [1:0]       r_ptr;

  logic             w_load;
  logic             w_any;
  logic [1:0]       w_gnt;
  logic [1:0]       w_idx;
  logic [WIDTH-1:0] w_data;

  assign w_load = !r_valid || out_ready;

  // Scan from the farthest slot back to the pointer so the nearest request wins.
  always_comb begin
    w_any = 1'b0;
    w_gnt = 2'd0;
    w_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k);
      if (in_valid[w_idx]) begin
        w_any = 1'b1;
        w_gnt = w_idx;
      end
    end
  end

  always_comb begin
    in_ready = 4'b0000;
    if (!rst && w_any && w_load) begin
      in_ready[w_gnt] = 1'b1;
    end
  end

  always_comb begin
    case (w_gnt)
      2'd0:    w_data = in_data0;
      2'd1:    w_data = in_data1;
      2'd2:    w_data = in_data2;
      default: w_data = in_data3;
    endcase
  end

  // An idle load empties the register but keeps the last data and select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= 2'd0;
      r_ptr   <= 2'd0;
    end else if (w_load) begin
      if (w_any) begin
        r_valid <= 1'b1;
        r_data  <= w_data;
        r_sel   <= w_gnt;
        r_ptr   <= w_gnt + 2'd1;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule

// File: tb/tb_rr_arb_mux_4.sv
// Self-checking bench for rr_arb_mux_4: directed scenarios plus a randomized run
// compared against a distance-based round-robin reference model.
module tb_rr_arb_mux_4;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       in_valid = 4'b0000;
  logic [3:0]       in_ready;
  logic [WIDTH-1:0] dIn [4];
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;

  int checks = 0;
  int failures = 0;

  logic             mValid;
  logic [WIDTH-1:0] mData;
  logic [1:0]       mSel;
  int               mPtr;

  always #5 clk = ~clk;

  rr_arb_mux_4 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data0  (dIn[0]),
    .in_data1  (dIn[1]),
    .in_data2  (dIn[2]),
    .in_data3  (dIn[3]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  // Winner is the requesting channel at the smallest rotational distance from the pointer.
  function automatic int grantOf(input logic [3:0] v, input int ptr);
    int best;
    int bestDist;
    int d;
    best = -1;
    bestDist = 99;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        d = (i - ptr + 4) % 4;
        if (d < bestDist) begin
          bestDist = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [3:0] expReady();
    int g;
    g = grantOf(in_valid, mPtr);
    if (rst || g < 0 || !(!mValid || out_ready)) return 4'b0000;
    return 4'(1) << g;
  endfunction

  task automatic modelReset();
    mValid = 1'b0;
    mData  = '0;
    mSel   = 2'd0;
    mPtr   = 0;
  endtask

  task automatic modelClock();
    int g;
    g = grantOf(in_valid, mPtr);
    if (!mValid || out_ready) begin
      if (g >= 0) begin
        mValid = 1'b1;
        mData  = dIn[g];
        mSel   = 2'(g);
        mPtr   = (g + 1) % 4;
      end else begin
        mValid = 1'b0;
      end
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic ordy);
    in_valid  = v;
    out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    modelClock();
    #1;
  endtask

  task automatic test_reset();
    dIn[0] = 4'h1; dIn[1] = 4'h2; dIn[2] = 4'h3; dIn[3] = 4'h4;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    modelReset();
    #2;
    checks++;
    if ({out_valid, out_sel, out_data} !== 7'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got v=%b sel=%0d data=%h want all zero", out_valid, out_sel, out_data);
    end
    checks++;
    if (in_ready !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_ready got %b want 0000", in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 8; k++) begin
      drive(4'hF, 1'b1);
      checks++;
      if (in_ready !== (4'(1) << (k % 4)) || in_ready !== expReady()) begin
        failures++;
        $display("[TB] FAIL rr_ready[%0d] got %b want %b", k, in_ready, 4'(1) << (k % 4));
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'(k % 4) || out_data !== 4'(k % 4 + 1)
          || {out_valid, out_sel, out_data} !== {mValid, mSel, mData}) begin
        failures++;
        $display("[TB] FAIL rr_out[%0d] got v=%b sel=%0d data=%h want v=1 sel=%0d data=%0d",
                 k, out_valid, out_sel, out_data, k % 4, k % 4 + 1);
      end
    end
  endtask

  task automatic test_single();
    dIn[2] = 4'h7;
    for (int k = 0; k < 5; k++) begin
      drive(4'b0100, 1'b1);
      checks++;
      if (in_ready !== 4'b0100) begin
        failures++;
        $display("[TB] FAIL single_ready[%0d] got %b want 0100", k, in_ready);
      end
      tick();
      checks++;
      if ({out_valid, out_sel, out_data} !== {1'b1, 2'd2, 4'h7} || mPtr != 3) begin
        failures++;
        $display("[TB] FAIL single_out[%0d] got v=%b sel=%0d data=%h want v=1 sel=2 data=7",
                 k, out_valid, out_sel, out_data);
      end
    end
  endtask

  task automatic test_backpressure();
    dIn[0] = 4'h8;
    dIn[1] = 4'h9;
    drive(4'b0011, 1'b1);
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL bp_first_ready got %b want 0001", in_ready);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(4'b0011, 1'b0);
      checks++;
      if (in_ready !== 4'b0000) begin
        failures++;
        $display("[TB] FAIL bp_stall_ready[%0d] got %b want 0000", k, in_ready);
      end
      tick();
      checks++;
      if ({out_valid, out_sel, out_data} !== {1'b1, 2'd0, 4'h8}) begin
        failures++;
        $display("[TB] FAIL bp_frozen[%0d] got v=%b sel=%0d data=%h want v=1 sel=0 data=8",
                 k, out_valid, out_sel, out_data);
      end
    end
    drive(4'b0011, 1'b1);
    checks++;
    if (in_ready !== 4'b0010) begin
      failures++;
      $display("[TB] FAIL bp_release_ready got %b want 0010", in_ready);
    end
    tick();
    checks++;
    if ({out_valid, out_sel, out_data} !== {1'b1, 2'd1, 4'h9}) begin
      failures++;
      $display("[TB] FAIL bp_release_ch1 got v=%b sel=%0d data=%h want v=1 sel=1 data=9",
               out_valid, out_sel, out_data);
    end
    drive(4'b0011, 1'b1);
    tick();
    checks++;
    if ({out_valid, out_sel, out_data} !== {1'b1, 2'd0, 4'h8}) begin
      failures++;
      $display("[TB] FAIL bp_release_ch0 got v=%b sel=%0d data=%h want v=1 sel=0 data=8",
               out_valid, out_sel, out_data);
    end
  endtask

  task automatic test_pointer_wrap();
    dIn[3] = 4'hC;
    drive(4'b1000, 1'b1);
    tick();
    checks++;
    if ({out_valid, out_sel, out_data} !== {1'b1, 2'd3, 4'hC}) begin
      failures++;
      $display("[TB] FAIL wrap_ch3 got v=%b sel=%0d data=%h want v=1 sel=3 data=c",
               out_valid, out_sel, out_data);
    end
    drive(4'b1001, 1'b1);
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL wrap_ready got %b want 0001", in_ready);
    end
    tick();
    checks++;
    if (out_sel !== 2'd0 || out_data !== 4'h8) begin
      failures++;
      $display("[TB] FAIL wrap_ch0 got sel=%0d data=%h want sel=0 data=8", out_sel, out_data);
    end
    drive(4'b1001, 1'b1);
    tick();
    checks++;
    if (out_sel !== 2'd3 || out_data !== 4'hC) begin
      failures++;
      $display("[TB] FAIL wrap_ch3_again got sel=%0d data=%h want sel=3 data=c", out_sel, out_data);
    end
  endtask

  task automatic test_idle_gap();
    for (int k = 0; k < 2; k++) begin
      drive(4'b0000, 1'b1);
      tick();
      checks++;
      if ({out_valid, out_sel, out_data} !== {1'b0, 2'd3, 4'hC}) begin
        failures++;
        $display("[TB] FAIL idle[%0d] got v=%b sel=%0d data=%h want v=0 sel=3 data=c",
                 k, out_valid, out_sel, out_data);
      end
    end
    dIn[1] = 4'h5;
    drive(4'b0010, 1'b1);
    checks++;
    if (in_ready !== 4'b0010) begin
      failures++;
      $display("[TB] FAIL idle_wake_ready got %b want 0010", in_ready);
    end
    tick();
    checks++;
    if ({out_valid, out_sel, out_data} !== {1'b1, 2'd1, 4'h5}) begin
      failures++;
      $display("[TB] FAIL idle_wake got v=%b sel=%0d data=%h want v=1 sel=1 data=5",
               out_valid, out_sel, out_data);
    end
  endtask

  task automatic test_reset_midstream();
    dIn[0] = 4'hA;
    drive(4'b0001, 1'b1);
    tick();
    checks++;
    if ({out_valid, out_sel, out_data} !== {1'b1, 2'd0, 4'hA}) begin
      failures++;
      $display("[TB] FAIL mid_load got v=%b sel=%0d data=%h want v=1 sel=0 data=a",
               out_valid, out_sel, out_data);
    end
    drive(4'hF, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_sel, out_data} !== 7'd0 || in_ready !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL mid_reset got v=%b sel=%0d data=%h ready=%b want all zero",
               out_valid, out_sel, out_data, in_ready);
    end
    #1;
    rst = 1'b0;
    modelReset();
    drive(4'hF, 1'b1);
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL mid_after_ready got %b want 0001", in_ready);
    end
    tick();
    checks++;
    if ({out_valid, out_sel, out_data} !== {1'b1, 2'd0, 4'hA}) begin
      failures++;
      $display("[TB] FAIL mid_after got v=%b sel=%0d data=%h want v=1 sel=0 data=a",
               out_valid, out_sel, out_data);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      for (int c = 0; c < 4; c++) dIn[c] = 4'($urandom);
      drive(4'($urandom), ($urandom_range(0, 3) != 0));
      checks++;
      if (in_ready !== expReady()) begin
        failures++;
        $display("[TB] FAIL rand_ready[%0d] got %b want %b", k, in_ready, expReady());
      end
      tick();
      checks++;
      if ({out_valid, out_sel, out_data} !== {mValid, mSel, mData}) begin
        failures++;
        $display("[TB] FAIL rand_out[%0d] got v=%b sel=%0d data=%h want v=%b sel=%0d data=%h",
                 k, out_valid, out_sel, out_data, mValid, mSel, mData);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_pointer_wrap();
    test_idle_gap();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux_4.md
Name: rr_arb_mux_4

Overview:
- 4-channel round-robin arbiter that feeds a 4:1 nibble multiplexer stage.
- Takes four valid/ready input channels, picks one per cycle with rotating priority, and registers the winner's data plus its 2-bit channel index (the mux select) into a one-entry output register.
- Sits directly upstream of the 4:1 mux datapath, producing the `sel` and data stream that stage consumes.

Parameters:
- WIDTH, 4, data width of each channel and of the output.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  4  per-channel valid; bit i belongs to channel i.
- in_ready  output  4  per-channel ready; at most one bit high per cycle.
- in_data0  input  WIDTH  channel 0 data.
- in_data1  input  WIDTH  channel 1 data.
- in_data2  input  WIDTH  channel 2 data.
- in_data3  input  WIDTH  channel 3 data.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  WIDTH  registered data of the granted channel.
- out_sel  output  2  registered index of the granted channel.

Behaviour:
- Reset, asynchronous on rst=1: out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0.
  - in_ready=0 while rst is high.
  - Reset mid-transfer drops the held beat; no partial state survives.
- Output register load enable: load = !out_valid || out_ready.
- Grant (combinational):
  - g is the first channel i with in_valid[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - in_ready[g] = load. All other in_ready bits are 0.
  - If no in_valid bit is set, in_ready=0.
  - in_ready depends combinationally on in_valid, out_valid, out_ready and ptr. Upstream must not make in_valid depend on in_ready.
- Transfer, on a cycle with load=1 and some in_valid set. Next edge:
  - out_valid<=1
  - out_data<=in_data[g]
  - out_sel<=g
  - ptr<=(g+1) mod 4
- Load with no requests: out_valid<=0; out_data and out_sel hold their previous values; ptr holds.
- Stall (out_valid=1, out_ready=0): out_valid, out_data, out_sel and ptr all hold; in_ready=0.
- Latency and throughput:
  - Accepted input appears on the output exactly 1 cycle later.
  - Full throughput: 1 beat/cycle when out_ready stays high.
- Simultaneous drain and fill: out_valid=1, out_ready=1 and a request present means the output beat leaves and the new beat loads on the same edge, with no bubble.
- Fairness:
  - A channel held valid is granted within at most 4 consecutive grants.
  - Granting channel 3 wraps ptr to 0.
- Input rules:
  - Channels must hold in_valid and data stable until accepted. Violations are not checked.
  - A channel dropping valid before acceptance is simply not granted.
- Output protocol: out_data and out_sel are stable while out_valid=1 and out_ready=0.

Test Plan:
- Reset mid-stream:
  - Stimulus: assert rst while out_valid=1 and data=4'hA.
  - Response: out_valid, out_data and out_sel go to 0 immediately, without waiting for a clock edge. in_ready=0 while rst is high. After release, the first grant with all channels valid goes to channel 0.
- All four channels always valid, out_ready=1, data 4'h1, 4'h2, 4'h3, 4'h4:
  - out_sel sequence is 0,1,2,3,0,1,...
  - out_data sequence is 1,2,3,4,1,...
  - out_valid stays high every cycle after the first.
- Single requester, channel 2 only, data 4'h7, out_ready=1:
  - Channel 2 is granted every cycle; out_sel=2 and out_data=7 continuously.
  - ptr stays at 3 and channel 2 is still found on wrap.
- Backpressure:
  - Stimulus: channels 0 and 1 valid; hold out_ready=0 for 3 cycles after the first beat.
  - Response: out_data and out_sel are frozen; in_ready=4'b0000.
  - On release, the next beat is channel 1, then channel 0. No beat is lost or duplicated.
- Pointer wrap:
  - Stimulus: grant channel 3, then channels 0 and 3 valid.
  - Response: channel 0 is granted next, then channel 3.
- Idle gap:
  - Stimulus: no requests for 2 cycles with out_ready=1.
  - Response: out_valid drops to 0 one cycle after the last beat is consumed; out_data holds its last value.
  - A new request on channel 1 with data 4'h5 gives out_valid=1, out_sel=1, out_data=5 on the next cycle.
